// File: rtl/plic_arb_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// plic_arb_seq_ctrl_if
// Bundles the hart arbitration controller's request/config/claim inputs and
// its interrupt outputs.
//   master : arbitration requester / gateway side; drives start, flush,
//            source vectors, thresholds and claim pulses
//   slave  : arbitration controller; drives ack, busy, M/S requests and IDs
// ----------------------------------------------------------------------------
interface plic_arb_seq_ctrl_if #(
   parameter int unsigned INT_NUM  = 256,
   parameter int unsigned PRIO_BIT = 5,
   parameter int unsigned ID_BIT   = 8
);
   logic                         arb_start;
   logic                         arb_flush;
   logic [INT_NUM-1:0]           int_req;
   logic [INT_NUM-1:0]           int_en;
   logic [INT_NUM-1:0]           int_mmode;
   logic [INT_NUM*PRIO_BIT-1:0]  int_prio;
   logic [PRIO_BIT-1:0]          prio_mth;
   logic [PRIO_BIT-1:0]          prio_sth;
   logic                         mint_claim;
   logic                         sint_claim;
   logic                         arb_start_ack;
   logic                         arb_busy;
   logic                         mint_req;
   logic                         sint_req;
   logic [ID_BIT-1:0]            mint_id;
   logic [ID_BIT-1:0]            sint_id;

   modport master (
      output arb_start, arb_flush, int_req, int_en, int_mmode, int_prio,
             prio_mth, prio_sth, mint_claim, sint_claim,
      input  arb_start_ack, arb_busy, mint_req, sint_req, mint_id, sint_id
   );

   modport slave (
      input  arb_start, arb_flush, int_req, int_en, int_mmode, int_prio,
             prio_mth, prio_sth, mint_claim, sint_claim,
      output arb_start_ack, arb_busy, mint_req, sint_req, mint_id, sint_id
   );
endinterface

// File: rtl/plic_arb_seq_ctrl.sv
// ----------------------------------------------------------------------------
// plic_arb_seq_ctrl
// Per-hart PLIC arbitration controller. Scans INT_NUM sources, ECH_RD per
// cycle, keeping running M-mode and S-mode winners (highest priority, lowest
// ID on ties), then applies the M/S thresholds and drives the hart requests.
// Ports:
//   plic_clk   clock
//   plicrst_b  asynchronous active-low reset
//   bus        plic_arb_seq_ctrl_if slave modport (start/flush handshake,
//              source vectors, thresholds, claims, requests and IDs)
// ----------------------------------------------------------------------------
module plic_arb_seq_ctrl #(
   parameter int unsigned INT_NUM  = 256,
   parameter int unsigned ECH_RD   = 32,
   parameter int unsigned PRIO_BIT = 5,
   parameter int unsigned ID_BIT   = 8
) (
   input  logic                 plic_clk,
   input  logic                 plicrst_b,
   plic_arb_seq_ctrl_if.slave   bus
);
   localparam int unsigned RD_NUM = INT_NUM / ECH_RD;
   localparam int unsigned RND_W  = (RD_NUM > 1) ? $clog2(RD_NUM) : 1;
   localparam int unsigned IDX_W  = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;
   localparam logic [RND_W-1:0] LastRnd = RND_W'(RD_NUM - 1);

   typedef enum logic [1:0] {StIdle, StArb, StDelay, StWrite} state_e;

   state_e               state_q;
   logic [RND_W-1:0]     round_q;
   logic                 start_pend_q;
   logic [PRIO_BIT-1:0]  best_m_prio_q, best_s_prio_q;
   logic [ID_BIT-1:0]    best_m_id_q, best_s_id_q;
   // Priority of the currently presented winner, for the threshold-raise drop
   logic [PRIO_BIT-1:0]  out_m_prio_q, out_s_prio_q;
   logic                 mint_req_q, sint_req_q;
   logic [ID_BIT-1:0]    mint_id_q, sint_id_q;

   logic [PRIO_BIT-1:0]  prio_arr [INT_NUM];
   logic [PRIO_BIT-1:0]  cand_m_prio, cand_s_prio, cur_prio;
   logic [ID_BIT-1:0]    cand_m_id, cand_s_id;
   logic [IDX_W-1:0]     idx;
   logic                 elig;
   logic                 launch;

   for (genvar g = 0; g < INT_NUM; g++) begin : g_prio
      assign prio_arr[g] = bus.int_prio[g*PRIO_BIT +: PRIO_BIT];
   end

   // Best candidate of the current round; ascending scan with strict compare
   // keeps the lowest ID on priority ties.
   always_comb begin
      cand_m_prio = '0;
      cand_m_id   = '0;
      cand_s_prio = '0;
      cand_s_id   = '0;
      idx         = '0;
      cur_prio    = '0;
      elig        = 1'b0;
      for (int unsigned j = 0; j < ECH_RD; j++) begin
         idx      = IDX_W'(32'(round_q) * ECH_RD + j);
         cur_prio = prio_arr[idx];
         elig     = bus.int_req[idx] & bus.int_en[idx] & (cur_prio != '0) & (idx != '0);
         if (elig && bus.int_mmode[idx] && (cur_prio > cand_m_prio)) begin
            cand_m_prio = cur_prio;
            cand_m_id   = ID_BIT'(idx);
         end
         if (elig && !bus.int_mmode[idx] && (cur_prio > cand_s_prio)) begin
            cand_s_prio = cur_prio;
            cand_s_id   = ID_BIT'(idx);
         end
      end
   end

   // Flush overrides a same-cycle start, so it also suppresses the ack.
   assign launch            = (state_q == StIdle) & (bus.arb_start | start_pend_q) & ~bus.arb_flush;
   assign bus.arb_start_ack = launch;
   assign bus.arb_busy      = (state_q != StIdle);
   assign bus.mint_req      = mint_req_q;
   assign bus.sint_req      = sint_req_q;
   assign bus.mint_id       = mint_id_q;
   assign bus.sint_id       = sint_id_q;

   always_ff @(posedge plic_clk or negedge plicrst_b) begin
      if (!plicrst_b) begin
         state_q       <= StIdle;
         round_q       <= '0;
         start_pend_q  <= 1'b0;
         best_m_prio_q <= '0;
         best_m_id_q   <= '0;
         best_s_prio_q <= '0;
         best_s_id_q   <= '0;
         out_m_prio_q  <= '0;
         out_s_prio_q  <= '0;
         mint_req_q    <= 1'b0;
         mint_id_q     <= '0;
         sint_req_q    <= 1'b0;
         sint_id_q     <= '0;
      end else if (bus.arb_flush) begin
         // Abort the pass; hart-facing outputs keep their last value.
         state_q       <= StIdle;
         round_q       <= '0;
         start_pend_q  <= 1'b0;
         best_m_prio_q <= '0;
         best_m_id_q   <= '0;
         best_s_prio_q <= '0;
         best_s_id_q   <= '0;
      end else begin
         if (bus.arb_start && (state_q != StIdle)) begin
            start_pend_q <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (launch) begin
                  state_q       <= StArb;
                  start_pend_q  <= 1'b0;
                  round_q       <= '0;
                  best_m_prio_q <= '0;
                  best_m_id_q   <= '0;
                  best_s_prio_q <= '0;
                  best_s_id_q   <= '0;
               end
            end
            StArb: begin
               if (cand_m_prio > best_m_prio_q) begin
                  best_m_prio_q <= cand_m_prio;
                  best_m_id_q   <= cand_m_id;
               end
               if (cand_s_prio > best_s_prio_q) begin
                  best_s_prio_q <= cand_s_prio;
                  best_s_id_q   <= cand_s_id;
               end
               if (round_q == LastRnd) begin
                  round_q <= '0;
                  state_q <= StDelay;
               end else begin
                  round_q <= round_q + 1'b1;
               end
            end
            StDelay: state_q <= StWrite;
            StWrite: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase

         if (state_q == StWrite) begin
            out_m_prio_q <= best_m_prio_q;
            out_s_prio_q <= best_s_prio_q;
            mint_req_q   <= best_m_prio_q > bus.prio_mth;
            mint_id_q    <= (best_m_prio_q > bus.prio_mth) ? best_m_id_q : '0;
            sint_req_q   <= best_s_prio_q > bus.prio_sth;
            sint_id_q    <= (best_s_prio_q > bus.prio_sth) ? best_s_id_q : '0;
         end else begin
            if (bus.mint_claim) begin
               mint_req_q <= 1'b0;
               mint_id_q  <= '0;
            end else if (out_m_prio_q <= bus.prio_mth) begin
               mint_req_q <= 1'b0;
            end
            if (bus.sint_claim) begin
               sint_req_q <= 1'b0;
               sint_id_q  <= '0;
            end else if (out_s_prio_q <= bus.prio_sth) begin
               sint_req_q <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_plic_arb_seq_ctrl.sv
module tb_plic_arb_seq_ctrl;
   localparam int INT_NUM  = 256;
   localparam int ECH_RD   = 32;
   localparam int PRIO_BIT = 5;
   localparam int ID_BIT   = 8;
   localparam int RD_NUM   = INT_NUM / ECH_RD;

   logic plic_clk = 1'b0;
   logic plicrst_b;
   always #5 plic_clk = ~plic_clk;

   plic_arb_seq_ctrl_if #(.INT_NUM(INT_NUM), .PRIO_BIT(PRIO_BIT), .ID_BIT(ID_BIT)) bus ();

   plic_arb_seq_ctrl #(
      .INT_NUM (INT_NUM),
      .ECH_RD  (ECH_RD),
      .PRIO_BIT(PRIO_BIT),
      .ID_BIT  (ID_BIT)
   ) dut (
      .plic_clk (plic_clk),
      .plicrst_b(plicrst_b),
      .bus      (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [INT_NUM-1:0]  req_v, en_v, mm_v;
   logic [PRIO_BIT-1:0] prio_a [INT_NUM];
   logic [PRIO_BIT-1:0] mth_v, sth_v;
   logic                exp_mreq, exp_sreq;
   logic [ID_BIT-1:0]   exp_mid, exp_sid;

   // Reference: global winner = max priority over eligible sources, first
   // (lowest) ID wins a tie; then threshold.
   function automatic void model();
      int bm_p = 0, bm_id = 0, bs_p = 0, bs_id = 0;
      for (int i = 1; i < INT_NUM; i++) begin
         if (req_v[i] && en_v[i] && prio_a[i] != 0) begin
            if (mm_v[i] && int'(prio_a[i]) > bm_p) begin bm_p = int'(prio_a[i]); bm_id = i; end
            if (!mm_v[i] && int'(prio_a[i]) > bs_p) begin bs_p = int'(prio_a[i]); bs_id = i; end
         end
      end
      exp_mreq = bm_p > int'(mth_v);
      exp_mid  = exp_mreq ? ID_BIT'(bm_id) : '0;
      exp_sreq = bs_p > int'(sth_v);
      exp_sid  = exp_sreq ? ID_BIT'(bs_id) : '0;
   endfunction

   task automatic clear_cfg();
      req_v = '0; en_v = '0; mm_v = '0; mth_v = '0; sth_v = '0;
      for (int i = 0; i < INT_NUM; i++) prio_a[i] = '0;
   endtask

   task automatic apply();
      bus.int_req = req_v; bus.int_en = en_v; bus.int_mmode = mm_v;
      bus.prio_mth = mth_v; bus.prio_sth = sth_v;
      for (int i = 0; i < INT_NUM; i++) bus.int_prio[i*PRIO_BIT +: PRIO_BIT] = prio_a[i];
   endtask

   task automatic add_src(input int id, input logic mm, input int p);
      req_v[id] = 1'b1; en_v[id] = 1'b1; mm_v[id] = mm; prio_a[id] = PRIO_BIT'(p);
   endtask

   // Launch one pass from IDLE, check ack, busy length and resulting outputs.
   task automatic run_pass(input string name);
      int cnt;
      @(negedge plic_clk);
      bus.arb_start = 1'b1;
      #1;
      vectors++;
      if (bus.arb_start_ack !== 1'b1) begin
         miscompares++; $display("FAIL %s ack: got %b want 1", name, bus.arb_start_ack);
      end
      @(negedge plic_clk);
      bus.arb_start = 1'b0;
      cnt = 0;
      while (bus.arb_busy === 1'b1 && cnt < 100) begin cnt++; @(negedge plic_clk); end
      vectors++;
      if (cnt != RD_NUM + 2) begin
         miscompares++; $display("FAIL %s busy_len: got %0d want %0d", name, cnt, RD_NUM + 2);
      end
      model();
      vectors++;
      if ({bus.mint_req, bus.mint_id} !== {exp_mreq, exp_mid}) begin
         miscompares++;
         $display("FAIL %s m_out: got req=%b id=%0d want req=%b id=%0d", name, bus.mint_req,
                  bus.mint_id, exp_mreq, exp_mid);
      end
      vectors++;
      if ({bus.sint_req, bus.sint_id} !== {exp_sreq, exp_sid}) begin
         miscompares++;
         $display("FAIL %s s_out: got req=%b id=%0d want req=%b id=%0d", name, bus.sint_req,
                  bus.sint_id, exp_sreq, exp_sid);
      end
   endtask

   task automatic test_reset();
      plicrst_b = 1'b0;
      bus.arb_start = 0; bus.arb_flush = 0; bus.mint_claim = 0; bus.sint_claim = 0;
      clear_cfg(); apply();
      repeat (3) @(negedge plic_clk);
      plicrst_b = 1'b1;
      @(negedge plic_clk);
      vectors++;
      if ({bus.arb_start_ack, bus.arb_busy, bus.mint_req, bus.sint_req} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_flags: got ack=%b busy=%b mreq=%b sreq=%b want 0000",
                  bus.arb_start_ack, bus.arb_busy, bus.mint_req, bus.sint_req);
      end
      vectors++;
      if ({bus.mint_id, bus.sint_id} !== '0) begin
         miscompares++; $display("FAIL reset_ids: got %0d/%0d want 0/0", bus.mint_id, bus.sint_id);
      end
   endtask

   task automatic test_empty();
      clear_cfg(); apply();
      run_pass("empty");
      vectors++;
      if (bus.arb_start_ack !== 1'b0) begin
         miscompares++; $display("FAIL empty_ack_idle: got %b want 0", bus.arb_start_ack);
      end
   endtask

   task automatic test_mmode_claim();
      clear_cfg();
      add_src(5, 1'b1, 3); add_src(40, 1'b1, 7); mth_v = 2;
      apply();
      run_pass("mmode");
      bus.mint_claim = 1'b1;
      @(negedge plic_clk);
      bus.mint_claim = 1'b0;
      vectors++;
      if ({bus.mint_req, bus.mint_id} !== {1'b0, 8'd0}) begin
         miscompares++;
         $display("FAIL mclaim: got req=%b id=%0d want req=0 id=0", bus.mint_req, bus.mint_id);
      end
   endtask

   task automatic test_tie_src0();
      clear_cfg();
      add_src(9, 1'b0, 4); add_src(70, 1'b0, 4); add_src(0, 1'b0, 31);
      apply();
      run_pass("tie");
      vectors++;
      if (bus.sint_id !== 8'd9) begin
         miscompares++; $display("FAIL tie_id: got %0d want 9", bus.sint_id);
      end
   endtask

   task automatic test_threshold_raise();
      clear_cfg();
      add_src(12, 1'b1, 3); add_src(20, 1'b0, 6); sth_v = 1;
      apply();
      run_pass("thr");
      bus.prio_mth = 3;
      @(negedge plic_clk);
      vectors++;
      if ({bus.mint_req, bus.sint_req, bus.sint_id} !== {1'b0, 1'b1, 8'd20}) begin
         miscompares++;
         $display("FAIL thr_raise: got mreq=%b sreq=%b sid=%0d want mreq=0 sreq=1 sid=20",
                  bus.mint_req, bus.sint_req, bus.sint_id);
      end
      mth_v = 3;
   endtask

   task automatic test_queued();
      int cnt;
      clear_cfg();
      add_src(30, 1'b0, 5); add_src(100, 1'b1, 2);
      apply();
      model();
      @(negedge plic_clk); bus.arb_start = 1'b1;
      @(negedge plic_clk); bus.arb_start = 1'b0;          // round 0
      @(negedge plic_clk);                                // round 1
      @(negedge plic_clk); bus.arb_start = 1'b1;          // round 2
      @(negedge plic_clk); bus.arb_start = 1'b0;
      @(negedge plic_clk); bus.arb_start = 1'b1;          // collapses with the first
      @(negedge plic_clk); bus.arb_start = 1'b0;
      cnt = 0;
      while (bus.arb_busy === 1'b1 && cnt < 100) begin cnt++; @(negedge plic_clk); end
      vectors++;
      if ({bus.arb_start_ack, bus.sint_id, bus.mint_id} !== {1'b1, exp_sid, exp_mid}) begin
         miscompares++;
         $display("FAIL queued_ack: got ack=%b sid=%0d mid=%0d want ack=1 sid=%0d mid=%0d",
                  bus.arb_start_ack, bus.sint_id, bus.mint_id, exp_sid, exp_mid);
      end
      @(negedge plic_clk);
      cnt = 0;
      while (bus.arb_busy === 1'b1 && cnt < 100) begin cnt++; @(negedge plic_clk); end
      vectors++;
      if (cnt != RD_NUM + 2) begin
         miscompares++; $display("FAIL queued_len: got %0d want %0d", cnt, RD_NUM + 2);
      end
      @(negedge plic_clk);
      vectors++;
      if ({bus.arb_start_ack, bus.arb_busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL queued_collapse: got ack=%b busy=%b want 00", bus.arb_start_ack,
                  bus.arb_busy);
      end
   endtask

   task automatic test_flush();
      clear_cfg();
      add_src(50, 1'b1, 9); mth_v = 1;
      apply();
      run_pass("flush_pre");
      clear_cfg();
      add_src(60, 1'b1, 12); mth_v = 1;
      apply();
      @(negedge plic_clk); bus.arb_start = 1'b1;
      @(negedge plic_clk); bus.arb_start = 1'b0;          // round 0
      repeat (3) @(negedge plic_clk);                     // round 3
      bus.arb_flush = 1'b1;
      @(negedge plic_clk);
      bus.arb_flush = 1'b0;
      vectors++;
      if ({bus.arb_busy, bus.mint_req, bus.mint_id} !== {1'b0, 1'b1, 8'd50}) begin
         miscompares++;
         $display("FAIL flush_hold: got busy=%b mreq=%b mid=%0d want busy=0 mreq=1 mid=50",
                  bus.arb_busy, bus.mint_req, bus.mint_id);
      end
      bus.arb_flush = 1'b1; bus.arb_start = 1'b1;
      #1;
      vectors++;
      if (bus.arb_start_ack !== 1'b0) begin
         miscompares++; $display("FAIL flush_override_ack: got %b want 0", bus.arb_start_ack);
      end
      @(negedge plic_clk);
      bus.arb_flush = 1'b0; bus.arb_start = 1'b0;
      vectors++;
      if (bus.arb_busy !== 1'b0) begin
         miscompares++; $display("FAIL flush_override_busy: got %b want 0", bus.arb_busy);
      end
      run_pass("flush_restart");
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         for (int w = 0; w < INT_NUM / 32; w++) begin
            req_v[w*32 +: 32] = $urandom();
            en_v[w*32 +: 32]  = $urandom();
            mm_v[w*32 +: 32]  = $urandom();
         end
         // Sparse pending sets make the per-round choice matter.
         if (n % 2 == 1) req_v = req_v & {INT_NUM/32{32'($urandom()) & 32'($urandom())}};
         for (int i = 0; i < INT_NUM; i++) prio_a[i] = PRIO_BIT'($urandom_range(0, 31));
         mth_v = PRIO_BIT'($urandom_range(0, 31));
         sth_v = PRIO_BIT'($urandom_range(0, 31));
         apply();
         run_pass("random");
         if ($urandom_range(0, 1) == 1) begin
            bus.sint_claim = 1'b1;
            @(negedge plic_clk);
            bus.sint_claim = 1'b0;
            vectors++;
            if ({bus.sint_req, bus.sint_id, bus.mint_req, bus.mint_id} !==
                {1'b0, 8'd0, exp_mreq, exp_mid}) begin
               miscompares++;
               $display("FAIL rand_sclaim: got sreq=%b sid=%0d mreq=%b mid=%0d want 0/0/%b/%0d",
                        bus.sint_req, bus.sint_id, bus.mint_req, bus.mint_id, exp_mreq, exp_mid);
            end
         end
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_empty();
      test_mmode_claim();
      test_tie_src0();
      test_threshold_raise();
      test_queued();
      test_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
